// File: rtl/jzjpcc_execute_muldiv.sv
// Execute-stage M-extension unit: ALU pass-through, single-cycle multiply, radix-2 restoring divide.
// Define JZJPCC_DIVIDER_EN to build the divider; without it DIV/DIVU/REM/REMU return 0 on the multiply timing.
//
// state | meaning
// IDLE  | accept ALU ops directly, launch M ops
// DIV   | one restoring division step per cycle, counter counts down to 0
// DONE  | M result ready, memory-stage registers capture it
module jzjpcc_execute_muldiv #(
  parameter int PC_MAX_B = 31,
  parameter int XLEN     = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                flush_execute,
  input  logic                valid_execute,
  input  logic [XLEN-1:0]     operandA_execute,
  input  logic [XLEN-1:0]     operandB_execute,
  input  logic [XLEN-1:0]     aluResult_execute,
  input  logic [PC_MAX_B:2]   currentPC_execute,
  input  logic                mdEnable_execute,
  input  logic [2:0]          mdOperation_execute,
  input  logic [4:0]          rdAddr_execute,
  input  logic                rdWriteEnable_execute,
  output logic                stall_execute,
  output logic                valid_memory,
  output logic [XLEN-1:0]     result_memory,
  output logic [PC_MAX_B:2]   currentPC_memory,
  output logic [4:0]          rdAddr_memory,
  output logic                rdWriteEnable_memory
);

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  state_t          state, state_next;
  logic            start_md;
  logic            is_div_op;
  logic [XLEN-1:0] md_result;

  assign is_div_op = mdOperation_execute[2];
  assign start_md  = (state == IDLE) & valid_execute & mdEnable_execute & ~flush_execute & ~reset;

  // Sign-extending both operands to 2*XLEN lets one unsigned multiplier serve all signedness combinations.
  logic            mul_a_signed, mul_b_signed;
  logic [2*XLEN-1:0] mul_a_wide, mul_b_wide, mul_product;
  logic [XLEN-1:0] mul_result;

  assign mul_a_signed = (mdOperation_execute[1:0] != 2'b11);
  assign mul_b_signed = ~mdOperation_execute[1];
  assign mul_a_wide   = {{XLEN{mul_a_signed & operandA_execute[XLEN-1]}}, operandA_execute};
  assign mul_b_wide   = {{XLEN{mul_b_signed & operandB_execute[XLEN-1]}}, operandB_execute};
  assign mul_product  = mul_a_wide * mul_b_wide;
  assign mul_result   = (mdOperation_execute[1:0] == 2'b00) ? mul_product[XLEN-1:0]
                                                            : mul_product[2*XLEN-1:XLEN];

`ifdef JZJPCC_DIVIDER_EN
  localparam int CNT_W = $clog2(XLEN);

  logic [CNT_W-1:0] div_count;
  logic [XLEN-1:0]  div_quo, div_rem, div_dsr;
  logic             div_signed, a_neg, b_neg, div_by_zero, div_ovf;
  logic [XLEN-1:0]  a_mag, b_mag;
  logic [XLEN:0]    div_shift, div_diff;
  logic [XLEN-1:0]  quo_step, rem_step, quo_final, rem_final;
  logic [XLEN-1:0]  div_result, div_special;

  assign div_signed  = ~mdOperation_execute[0];
  assign a_neg       = div_signed & operandA_execute[XLEN-1];
  assign b_neg       = div_signed & operandB_execute[XLEN-1];
  assign a_mag       = a_neg ? -operandA_execute : operandA_execute;
  assign b_mag       = b_neg ? -operandB_execute : operandB_execute;
  assign div_by_zero = (operandB_execute == '0);
  assign div_ovf     = div_signed & (operandA_execute == {1'b1, {(XLEN-1){1'b0}}})
                       & (&operandB_execute);

  // Operands are held stable while stalled, so sign fix-up can use the live inputs.
  assign div_shift  = {div_rem, div_quo[XLEN-1]};
  assign div_diff   = div_shift - {1'b0, div_dsr};
  assign quo_step   = {div_quo[XLEN-2:0], ~div_diff[XLEN]};
  assign rem_step   = div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
  assign quo_final  = (a_neg ^ b_neg) ? -quo_step : quo_step;
  assign rem_final  = a_neg ? -rem_step : rem_step;
  assign div_result = mdOperation_execute[1] ? rem_final : quo_final;

  always_comb begin
    div_special = '0;
    if (div_by_zero) div_special = mdOperation_execute[1] ? operandA_execute : '1;
    else             div_special = mdOperation_execute[1] ? '0 : operandA_execute;
  end
`endif

  always_comb begin
    state_next    = state;
    stall_execute = 1'b0;
    case (state)
      IDLE: begin
        if (start_md) begin
          stall_execute = 1'b1;
`ifdef JZJPCC_DIVIDER_EN
          if (is_div_op & ~div_by_zero & ~div_ovf) state_next = DIV;
          else                                     state_next = DONE;
`else
          state_next = DONE;
`endif
        end
      end
`ifdef JZJPCC_DIVIDER_EN
      DIV: begin
        stall_execute = 1'b1;
        if (div_count == '0) state_next = DONE;
      end
`endif
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush_execute) state_next = IDLE;
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      md_result <= '0;
`ifdef JZJPCC_DIVIDER_EN
      div_count <= '0;
      div_quo   <= '0;
      div_rem   <= '0;
      div_dsr   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start_md) begin
`ifdef JZJPCC_DIVIDER_EN
            if (!is_div_op) begin
              md_result <= mul_result;
            end else if (div_by_zero | div_ovf) begin
              md_result <= div_special;
            end else begin
              div_quo   <= a_mag;
              div_rem   <= '0;
              div_dsr   <= b_mag;
              div_count <= CNT_W'(XLEN - 1);
            end
`else
            md_result <= is_div_op ? '0 : mul_result;
`endif
          end
        end
`ifdef JZJPCC_DIVIDER_EN
        DIV: begin
          div_quo   <= quo_step;
          div_rem   <= rem_step;
          div_count <= div_count - CNT_W'(1);
          if (div_count == '0) md_result <= div_result;
        end
`endif
        default: ;
      endcase
    end
  end

  // Memory-stage register: flush beats completion, stall cycles leave a bubble.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_memory         <= 1'b0;
      result_memory        <= '0;
      currentPC_memory     <= '0;
      rdAddr_memory        <= '0;
      rdWriteEnable_memory <= 1'b0;
    end else if (flush_execute) begin
      valid_memory <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (valid_execute & ~mdEnable_execute) begin
            valid_memory         <= 1'b1;
            result_memory        <= aluResult_execute;
            currentPC_memory     <= currentPC_execute;
            rdAddr_memory        <= rdAddr_execute;
            rdWriteEnable_memory <= rdWriteEnable_execute;
          end else begin
            valid_memory <= 1'b0;
          end
        end
        DONE: begin
          valid_memory         <= 1'b1;
          result_memory        <= md_result;
          currentPC_memory     <= currentPC_execute;
          rdAddr_memory        <= rdAddr_execute;
          rdWriteEnable_memory <= rdWriteEnable_execute;
        end
        default: valid_memory <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_jzjpcc_execute_muldiv.sv
// Directed bench for jzjpcc_execute_muldiv; exercises the divider paths when JZJPCC_DIVIDER_EN is defined.
module tb_jzjpcc_execute_muldiv;
  localparam int XLEN     = 32;
  localparam int PC_MAX_B = 31;

  localparam logic [2:0] OP_MUL = 3'b000, OP_MULH = 3'b001, OP_MULHSU = 3'b010, OP_MULHU = 3'b011;
  localparam logic [2:0] OP_DIV = 3'b100, OP_DIVU = 3'b101, OP_REM = 3'b110, OP_REMU = 3'b111;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              flush_execute = 1'b0;
  logic              valid_execute = 1'b0;
  logic [XLEN-1:0]   operandA_execute = '0;
  logic [XLEN-1:0]   operandB_execute = '0;
  logic [XLEN-1:0]   aluResult_execute = '0;
  logic [PC_MAX_B:2] currentPC_execute = '0;
  logic              mdEnable_execute = 1'b0;
  logic [2:0]        mdOperation_execute = '0;
  logic [4:0]        rdAddr_execute = '0;
  logic              rdWriteEnable_execute = 1'b0;
  logic              stall_execute;
  logic              valid_memory;
  logic [XLEN-1:0]   result_memory;
  logic [PC_MAX_B:2] currentPC_memory;
  logic [4:0]        rdAddr_memory;
  logic              rdWriteEnable_memory;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  jzjpcc_execute_muldiv #(.PC_MAX_B(PC_MAX_B), .XLEN(XLEN)) dut (
    .clock(clock), .reset(reset), .flush_execute(flush_execute), .valid_execute(valid_execute),
    .operandA_execute(operandA_execute), .operandB_execute(operandB_execute),
    .aluResult_execute(aluResult_execute), .currentPC_execute(currentPC_execute),
    .mdEnable_execute(mdEnable_execute), .mdOperation_execute(mdOperation_execute),
    .rdAddr_execute(rdAddr_execute), .rdWriteEnable_execute(rdWriteEnable_execute),
    .stall_execute(stall_execute), .valid_memory(valid_memory), .result_memory(result_memory),
    .currentPC_memory(currentPC_memory), .rdAddr_memory(rdAddr_memory),
    .rdWriteEnable_memory(rdWriteEnable_memory)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Presents one instruction, holds it while stalled, then checks latency, bubbles and result.
  task automatic run_op(input string tag, input logic md, input logic [2:0] op,
                        input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [XLEN-1:0] alu, input logic [4:0] rd,
                        input logic [XLEN-1:0] exp, input int lat);
    int   stalls = 0;
    int   early  = 0;
    logic s;
    valid_execute         = 1'b1;
    mdEnable_execute      = md;
    mdOperation_execute   = op;
    operandA_execute      = a;
    operandB_execute      = b;
    aluResult_execute     = alu;
    rdAddr_execute        = rd;
    rdWriteEnable_execute = 1'b1;
    currentPC_execute     = 30'(rd) + 30'h100;
    for (int k = 1; k <= lat; k++) begin
      #1;
      s = stall_execute;
      if (s) stalls++;
      @(posedge clock);
      #1;
      if (!s) begin
        valid_execute    = 1'b0;
        mdEnable_execute = 1'b0;
      end
      if (valid_memory && k < lat) early++;
    end
    valid_execute    = 1'b0;
    mdEnable_execute = 1'b0;
    chk({tag, " valid"}, 64'(valid_memory), 64'd1);
    chk({tag, " result"}, 64'(result_memory), 64'(exp));
    chk({tag, " rd"}, 64'(rdAddr_memory), 64'(rd));
    chk({tag, " stall_cycles"}, 64'(stalls), 64'(lat - 1));
    chk({tag, " early_valid"}, 64'(early), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    tick();
    chk("rst valid", 64'(valid_memory), 64'd0);
    chk("rst result", 64'(result_memory), 64'd0);
    chk("rst pc", 64'(currentPC_memory), 64'd0);
    chk("rst rd", 64'(rdAddr_memory), 64'd0);
    chk("rst we", 64'(rdWriteEnable_memory), 64'd0);
    chk("rst stall", 64'(stall_execute), 64'd0);
    reset = 1'b0;
    tick();

    run_op("alu", 1'b0, OP_MUL, 32'h0, 32'h0, 32'h12345678, 5'd5, 32'h12345678, 1);
    chk("alu pc", 64'(currentPC_memory), 64'h105);
    chk("alu we", 64'(rdWriteEnable_memory), 64'd1);

    // An M op without valid must neither stall nor start the FSM.
    mdEnable_execute    = 1'b1;
    mdOperation_execute = OP_MULH;
    operandA_execute    = 32'hFFFFFFFF;
    operandB_execute    = 32'h2;
    #1;
    chk("novalid stall", 64'(stall_execute), 64'd0);
    tick();
    chk("novalid vm1", 64'(valid_memory), 64'd0);
    tick();
    chk("novalid vm2", 64'(valid_memory), 64'd0);
    mdEnable_execute = 1'b0;

    run_op("mulh", 1'b1, OP_MULH, 32'hFFFFFFFF, 32'h2, 32'h0, 5'd6, 32'hFFFFFFFF, 2);
    run_op("mulhu", 1'b1, OP_MULHU, 32'hFFFFFFFF, 32'h2, 32'h0, 5'd7, 32'h00000001, 2);
    run_op("mul", 1'b1, OP_MUL, 32'h12345678, 32'h10, 32'h0, 5'd8, 32'h23456780, 2);
    run_op("mulhsu", 1'b1, OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 5'd9, 32'hFFFFFFFF, 2);

`ifdef JZJPCC_DIVIDER_EN
    run_op("div", 1'b1, OP_DIV, 32'hFFFFFFF9, 32'h2, 32'h0, 5'd10, 32'hFFFFFFFD, XLEN + 2);
    run_op("rem", 1'b1, OP_REM, 32'hFFFFFFF9, 32'h2, 32'h0, 5'd11, 32'hFFFFFFFF, XLEN + 2);
    run_op("divu", 1'b1, OP_DIVU, 32'd100, 32'd7, 32'h0, 5'd12, 32'd14, XLEN + 2);
    run_op("remu", 1'b1, OP_REMU, 32'd100, 32'd7, 32'h0, 5'd13, 32'd2, XLEN + 2);
    run_op("divu_z", 1'b1, OP_DIVU, 32'd5, 32'd0, 32'h0, 5'd14, 32'hFFFFFFFF, 2);
    run_op("remu_z", 1'b1, OP_REMU, 32'd5, 32'd0, 32'h0, 5'd15, 32'd5, 2);
    run_op("rem_ovf", 1'b1, OP_REM, 32'h80000000, 32'hFFFFFFFF, 32'h0, 5'd16, 32'h0, 2);
    run_op("div_ovf", 1'b1, OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 5'd17, 32'h80000000, 2);

    // Flush ten iterations into a division, then an ALU op must pass normally.
    valid_execute       = 1'b1;
    mdEnable_execute    = 1'b1;
    mdOperation_execute = OP_DIV;
    operandA_execute    = 32'hFFFFFFF9;
    operandB_execute    = 32'h2;
    repeat (11) tick();
    chk("flushdiv stall_pre", 64'(stall_execute), 64'd1);
    flush_execute = 1'b1;
    tick();
    flush_execute     = 1'b0;
    mdEnable_execute  = 1'b0;
    aluResult_execute = 32'hCAFEF00D;
    rdAddr_execute    = 5'd20;
    #1;
    chk("flushdiv stall", 64'(stall_execute), 64'd0);
    chk("flushdiv valid", 64'(valid_memory), 64'd0);
    tick();
    valid_execute = 1'b0;
    chk("flushdiv alu valid", 64'(valid_memory), 64'd1);
    chk("flushdiv alu result", 64'(result_memory), 64'hCAFEF00D);
    tick();
`else
    run_op("divu_off", 1'b1, OP_DIVU, 32'd9, 32'd3, 32'h0, 5'd12, 32'h0, 2);
    run_op("div_off", 1'b1, OP_DIV, 32'hFFFFFFF9, 32'h2, 32'h0, 5'd13, 32'h0, 2);
    run_op("remu_off", 1'b1, OP_REMU, 32'd5, 32'd0, 32'h0, 5'd14, 32'h0, 2);
`endif

    // Flush in DONE wins over completion.
    valid_execute       = 1'b1;
    mdEnable_execute    = 1'b1;
    mdOperation_execute = OP_MUL;
    operandA_execute    = 32'd3;
    operandB_execute    = 32'd4;
    tick();
    flush_execute = 1'b1;
    tick();
    flush_execute    = 1'b0;
    valid_execute    = 1'b0;
    mdEnable_execute = 1'b0;
    chk("flushdone vm", 64'(valid_memory), 64'd0);
    tick();
    chk("flushdone vm2", 64'(valid_memory), 64'd0);

    // Reset during an M op (iteration 20 of a division when the divider is built).
    valid_execute       = 1'b1;
    mdEnable_execute    = 1'b1;
    mdOperation_execute = OP_DIVU;
    operandA_execute    = 32'd100;
    operandB_execute    = 32'd7;
    rdAddr_execute      = 5'd21;
`ifdef JZJPCC_DIVIDER_EN
    repeat (21) tick();
`else
    tick();
`endif
    reset            = 1'b1;
    valid_execute    = 1'b0;
    mdEnable_execute = 1'b0;
    tick();
    chk("midrst valid", 64'(valid_memory), 64'd0);
    chk("midrst result", 64'(result_memory), 64'd0);
    chk("midrst pc", 64'(currentPC_memory), 64'd0);
    chk("midrst rd", 64'(rdAddr_memory), 64'd0);
    chk("midrst we", 64'(rdWriteEnable_memory), 64'd0);
    chk("midrst stall", 64'(stall_execute), 64'd0);
    reset = 1'b0;
    tick();
    chk("postrst stall", 64'(stall_execute), 64'd0);
    run_op("postrst mulhu", 1'b1, OP_MULHU, 32'hFFFFFFFF, 32'h2, 32'h0, 5'd22, 32'h00000001, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/jzjpcc_execute_muldiv.md
JZJPCC_EXECUTE_MULDIV -- requirements
Module: jzjpcc_execute_muldiv

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL update only on the rising edge of clock.
REQ-002 Parameter PC_MAX_B SHALL default to 31 and set the upper bit of the word-aligned PC field.
REQ-003 Parameter XLEN SHALL default to 32 and set the datapath width; legal values are 32 and 64.
REQ-004 Ports SHALL be:
- clock  in  1  system clock
- reset  in  1  synchronous active-high reset
- flush_execute  in  1  discard the instruction in execute
- valid_execute  in  1  instruction present in execute
- operandA_execute  in  XLEN  rs1 value
- operandB_execute  in  XLEN  rs2 value
- aluResult_execute  in  XLEN  result from the existing ALU
- currentPC_execute  in  PC_MAX_B-1  PC bits [PC_MAX_B:2]
- mdEnable_execute  in  1  1 = M-extension op, 0 = ALU pass-through
- mdOperation_execute  in  3  funct3 encoding: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
- rdAddr_execute  in  5  destination register
- rdWriteEnable_execute  in  1  destination write request
- stall_execute  out  1  upstream must hold the execute inputs
- valid_memory  out  1  the memory-stage register holds an instruction
- result_memory  out  XLEN  registered result
- currentPC_memory  out  PC_MAX_B-1  registered PC
- rdAddr_memory  out  5  registered destination
- rdWriteEnable_memory  out  1  registered write enable

Function
REQ-005 For an ALU op (valid_execute=1, mdEnable_execute=0), stall_execute SHALL be 0, and aluResult_execute, PC, rdAddr and rdWriteEnable SHALL appear on the _memory outputs one cycle later with valid_memory=1.
REQ-006 The FSM SHALL have three states: IDLE, DIV and DONE.
REQ-007 In IDLE, an M op SHALL assert stall_execute combinationally in that same cycle; MUL-family ops SHALL go to DONE, and DIV-family ops SHALL go to DIV with an iteration counter of XLEN-1.
REQ-008 MUL-family ops SHALL register the 2*XLEN-bit product on entry to DONE, with signedness as follows:
- MUL and MULH: signed x signed
- MULHSU: signed x unsigned
- MULHU: unsigned x unsigned
- MUL returns the low XLEN bits; the others return the high XLEN bits.
REQ-009 DIV SHALL perform one restoring radix-2 step per cycle with stall_execute=1, and SHALL go to DONE when the counter reaches 0.
REQ-010 Signed division SHALL operate on magnitudes; the quotient SHALL be negated if the operand signs differ, and the remainder SHALL take the sign of the dividend.
REQ-011 Divide-by-zero SHALL bypass DIV and go straight to DONE with quotient all-ones and remainder = dividend.
REQ-012 Signed overflow (most negative value / -1) SHALL bypass DIV and go straight to DONE with quotient = dividend and remainder 0.
REQ-013 In DONE, stall_execute SHALL be 0 and the _memory registers SHALL capture the result; the FSM SHALL then return to IDLE.
REQ-014 Latency from the first cycle the op is presented (cycle N) to valid_memory=1 SHALL be:
- ALU: N+1
- MUL family: N+2
- DIV family: N+XLEN+2
- divide special cases: N+2
REQ-015 While stall_execute=1, valid_memory SHALL be 0 (a bubble), and upstream SHALL hold all _execute inputs stable.
REQ-016 valid_execute=0 SHALL produce valid_memory=0 the next cycle and SHALL NOT start the FSM.
REQ-017 flush_execute=1 SHALL force the FSM to IDLE and valid_memory=0 on the next edge, abandoning any division in progress; flush SHALL take priority over completion in DONE.

Reset
REQ-018 Reset SHALL take priority over flush and all other inputs.
REQ-019 On reset, the FSM SHALL go to IDLE, the counter to 0, valid_memory to 0, result_memory to 0, currentPC_memory to 0, rdAddr_memory to 0 and rdWriteEnable_memory to 0.
REQ-020 Reset asserted mid-division SHALL abandon the operation, and stall_execute SHALL be 0 in the cycle after the reset edge.

Configuration
REQ-021 When macro JZJPCC_DIVIDER_EN is defined, the divider and the DIV state SHALL be compiled in as specified above.
REQ-022 When JZJPCC_DIVIDER_EN is undefined, DIV-family ops SHALL take the MUL path timing (IDLE->DONE) with result 0, and no divider logic SHALL be synthesised.

Verification
REQ-023 ALU pass-through: aluResult=0x12345678, rd=5, we=1 -> next cycle valid_memory=1, result_memory=0x12345678, rdAddr_memory=5, stall never asserted.
REQ-024 MULH: A=0xFFFFFFFF, B=0x00000002 -> stall for 1 cycle, result_memory=0xFFFFFFFF at N+2; MULHU with the same operands -> 0x00000001.
REQ-025 DIV: A=-7, B=2 (XLEN=32) -> stall for 33 cycles, quotient 0xFFFFFFFD at N+34; REM with the same operands -> 0xFFFFFFFF.
REQ-026 Special cases: DIVU 5/0 -> 0xFFFFFFFF at N+2; REM 0x80000000/-1 -> 0; DIV 0x80000000/-1 -> 0x80000000.
REQ-027 Flush at division iteration 10 -> next cycle stall=0 and valid_memory=0; a following ALU op completes normally.
REQ-028 Reset at division iteration 20 -> all outputs 0, FSM in IDLE; rerun with JZJPCC_DIVIDER_EN undefined -> DIVU 9/3 yields 0 at N+2.
